// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder step per cycle, LSB first, with a
// registered carry and valid/ready handshakes on both the operand and result sides.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf,
    output logic             mode_out
);

    // state | meaning
    // IDLE  | waiting for operands, in_ready=1
    // RUN   | one bit per cycle, counter = bit index
    // DONE  | result presented, waiting for out_ready
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             c_reg;
    logic             mode_reg;
    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] bit_mask;

    // Operand copies shift right so the current bit is always at position 0.
    assign s_bit    = a_sh[0] ^ b_sh[0] ^ c_reg;
    assign c_next   = (a_sh[0] & b_sh[0]) | (a_sh[0] & c_reg) | (b_sh[0] & c_reg);
    assign bit_mask = WIDTH'(1) << cnt;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            c_reg    <= 1'b0;
            mode_reg <= 1'b0;
            sum      <= '0;
            carry    <= 1'b0;
            ovf      <= 1'b0;
            mode_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= op_a;
                        b_sh     <= mode ? ~op_b : op_b;
                        mode_reg <= mode;
                        c_reg    <= mode;
                        cnt      <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum   <= (sum & ~bit_mask) | ({WIDTH{s_bit}} & bit_mask);
                    c_reg <= c_next;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    if (cnt == CNT_LAST) begin
                        // c_reg here is the carry into the MSB
                        state    <= DONE;
                        carry    <= c_next ^ mode_reg;
                        ovf      <= c_next ^ c_reg;
                        mode_out <= mode_reg;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
